// File: rtl/uart_rx_fsm_pkg.sv
// Shared UART definitions.
// Holds the receive FSM state encoding and the default frame timing
// constants, so the transmit and receive stages stay in agreement.
package uart_rx_fsm_pkg;

  // Receive FSM state encoding
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  // Default frame timing shared by uart_tx and uart_rx
  localparam int DEFAULT_BAUD_DIV  = 10416;
  localparam int DEFAULT_DATA_BITS = 8;

endpackage

// File: rtl/uart_rx_fsm_baud_counter.sv
// Bit-period counter with a mid-bit sample tick.
// Ports:
//   clk     - system clock
//   arst_n  - asynchronous active-low reset
//   en      - count enable (one decrement per enabled cycle)
//   restart - reload the counter to BAUD_DIV-1 (has priority over en)
//   tick    - high for one cycle when the enabled count equals MID_POINT
// After a restart the first tick comes BAUD_DIV-1-MID_POINT enabled cycles
// later; subsequent ticks are BAUD_DIV cycles apart.
module baud_counter
  import uart_rx_fsm_pkg::*;
#(
  parameter int BAUD_DIV  = DEFAULT_BAUD_DIV,
  parameter int MID_POINT = BAUD_DIV / 2
) (
  input  logic clk,
  input  logic arst_n,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] CNT_MID = CW'(MID_POINT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt <= CNT_TOP;
    end else if (restart) begin
      cnt <= CNT_TOP;
    end else if (en) begin
      cnt <= (cnt == '0) ? CNT_TOP : cnt - CW'(1);
    end
  end

  assign tick = en && (cnt == CNT_MID);

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receiver for 8N1-style frames.
// Ports:
//   clk       - system clock
//   arst_n    - asynchronous active-low reset
//   rx        - asynchronous serial input, idle high
//   rx_data   - last correctly framed word, LSB = first bit received
//   rx_valid  - one-cycle pulse when rx_data is updated
//   frame_err - one-cycle pulse when the stop bit is sampled low
//   busy      - high whenever the FSM is not idle
module uart_rx_fsm
  import uart_rx_fsm_pkg::*;
#(
  parameter int BAUD_DIV  = DEFAULT_BAUD_DIV,
  parameter int MID_POINT = BAUD_DIV / 2,
  parameter int DATA_BITS = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

  logic                 rx_meta;
  logic                 rx_s;
  logic                 rx_q;
  logic                 start_edge;
  logic [1:0]           state;
  logic [CW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 tick;
  logic                 restart;
  logic                 en;

  // Synchroniser and edge history reset high so reset cannot fake a start
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_q    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_q    <= rx_s;
    end
  end

  assign start_edge = !rx_s && rx_q;

  // Counter is held in reload while idle, so stray ticks cannot occur there
  // and every return to IDLE rearms it for the next frame.
  assign restart = (state == IDLE);
  assign en      = !restart;
  assign busy    = (state != IDLE);

  baud_counter #(
    .BAUD_DIV  (BAUD_DIV),
    .MID_POINT (MID_POINT)
  ) u_baud_counter (
    .clk     (clk),
    .arst_n  (arst_n),
    .en      (en),
    .restart (restart),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start_edge) begin
            state <= START;
          end
        end
        START: begin
          if (tick) begin
            // A high sample mid start bit means a glitch: drop it silently
            if (!rx_s) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        DATA: begin
          if (tick) begin
            shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
            bit_cnt   <= bit_cnt + CW'(1);
            if (bit_cnt == LAST_BIT) begin
              state <= STOP;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (rx_s) begin
              rx_data  <= shift_reg;
              rx_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
